rep3_encoder_tx: RTL and testbench

//  Transmit side of the repetition-3 link whose receiver rebuilds each data bit by 3-input majority vote.
//  - Latches a DATA_W-bit word on a start handshake.
//  - Sends the word serially, MSB first, each bit repeated REP times.
//  - Each repeated symbol is held BIT_CYCLES clocks, then the block signals done.
//  - Feeds the majority-vote decoder in the mini-project datapath.

---
 rtl/rep3_encoder_tx_if.sv | 23 ++
 rtl/rep3_encoder_tx.sv | 124 ++++++++++++
 tb/tb_rep3_encoder_tx.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rep3_encoder_tx_if.sv
// Bus bundle between the repetition-3 transmitter and its driver.
// master: the block that requests frames; slave: the encoder itself.
interface rep3_encoder_tx_if #(
    parameter int unsigned DATA_W = 5
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] err_inj;
    logic              tx_bit;
    logic              tx_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, data_in, err_inj,
        input  tx_bit, tx_valid, busy, done
    );

    modport slave (
        input  start, data_in, err_inj,
        output tx_bit, tx_valid, busy, done
    );
endinterface

// File: rtl/rep3_encoder_tx.sv
// Repetition-code serial transmitter: latches a word on start and sends it
// MSB first, each bit repeated REP times, each copy held BIT_CYCLES clocks.
// Optional feature macro: ERR_INJECT_EN -- when defined, err_inj marks payload
// bits whose middle copy is inverted (still decodable by majority vote).
module rep3_encoder_tx #(
    parameter int unsigned DATA_W     = 5,
    parameter int unsigned REP        = 3,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    rep3_encoder_tx_if.slave bus
);
    localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned REP_W = (REP > 1) ? $clog2(REP) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP - 1);
    localparam logic [REP_W-1:0] REP_MID  = REP_W'(REP / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic [BIT_W-1:0]  bit_cnt;

    logic [REP_W-1:0]  rep_nxt;
    logic [DATA_W-1:0] shreg_shl;
    logic              flip_nxt;

`ifdef ERR_INJECT_EN
    logic [DATA_W-1:0] inj;
`endif

    // Next-copy helpers; copy 0 is never the middle copy since REP >= 3.
    always_comb begin
        rep_nxt   = rep_cnt + REP_W'(1);
        shreg_shl = shreg << 1;
`ifdef ERR_INJECT_EN
        flip_nxt  = inj[DATA_W-1] && (rep_nxt == REP_MID);
`else
        flip_nxt  = 1'b0;
`endif
    end

    // Frame sequencer: counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            cyc_cnt      <= '0;
            rep_cnt      <= '0;
            bit_cnt      <= '0;
            bus.tx_bit   <= 1'b0;
            bus.tx_valid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
`ifdef ERR_INJECT_EN
            inj          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state        <= SEND;
                        shreg        <= bus.data_in;
                        cyc_cnt      <= '0;
                        rep_cnt      <= '0;
                        bit_cnt      <= '0;
                        bus.busy     <= 1'b1;
                        bus.tx_valid <= 1'b1;
                        bus.tx_bit   <= bus.data_in[DATA_W-1];
`ifdef ERR_INJECT_EN
                        inj          <= bus.err_inj;
`endif
                    end
                end
                SEND: begin
                    if (cyc_cnt != CYC_LAST) begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end else begin
                        cyc_cnt <= '0;
                        if (rep_cnt != REP_LAST) begin
                            rep_cnt    <= rep_nxt;
                            bus.tx_bit <= shreg[DATA_W-1] ^ flip_nxt;
                        end else begin
                            rep_cnt <= '0;
                            if (bit_cnt == BIT_LAST) begin
                                state        <= DONE;
                                bus.tx_valid <= 1'b0;
                                bus.tx_bit   <= 1'b0;
                                bus.done     <= 1'b1;
                            end else begin
                                bit_cnt    <= bit_cnt + BIT_W'(1);
                                shreg      <= shreg_shl;
                                bus.tx_bit <= shreg_shl[DATA_W-1];
`ifdef ERR_INJECT_EN
                                inj        <= inj << 1;
`endif
                            end
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rep3_encoder_tx.sv
// Bench for rep3_encoder_tx: a default instance and a BIT_CYCLES=2 instance,
// checked cycle by cycle against a symbol-list model of the frame.
module tb_rep3_encoder_tx;
    localparam int unsigned DW  = 5;
    localparam int unsigned REP = 3;
`ifdef ERR_INJECT_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] data_in;
    logic [DW-1:0] err_inj;
    int            sel;
    int            n_cmp;
    int            n_err;

    logic obs_bit, obs_valid, obs_busy, obs_done;

    always #5 clk = ~clk;

    rep3_encoder_tx_if #(.DATA_W(DW)) if0 ();
    rep3_encoder_tx_if #(.DATA_W(DW)) if1 ();

    assign if0.start   = start && (sel == 0);
    assign if1.start   = start && (sel == 1);
    assign if0.data_in = data_in;
    assign if1.data_in = data_in;
    assign if0.err_inj = err_inj;
    assign if1.err_inj = err_inj;

    rep3_encoder_tx #(.DATA_W(DW), .REP(REP), .BIT_CYCLES(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    rep3_encoder_tx #(.DATA_W(DW), .REP(REP), .BIT_CYCLES(2)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    always_comb begin
        if (sel == 1) begin
            obs_bit = if1.tx_bit; obs_valid = if1.tx_valid;
            obs_busy = if1.busy;  obs_done = if1.done;
        end else begin
            obs_bit = if0.tx_bit; obs_valid = if0.tx_valid;
            obs_busy = if0.busy;  obs_done = if0.done;
        end
    end

    function automatic int cur_bc();
        return (sel == 1) ? 2 : 1;
    endfunction

    // Runs one frame on the selected instance from an IDLE negedge; returns the
    // observed symbol stream (first symbol in the highest used bit).
    task automatic check_frame(input logic [DW-1:0] d, input logic [DW-1:0] inj,
                               input bit hold, input int poke_at, input bit poke_done,
                               output logic [63:0] cap, output int len);
        bit exp_q[$];
        int bc = cur_bc();
        for (int k = DW - 1; k >= 0; k--)
            for (int r = 0; r < REP; r++)
                for (int c = 0; c < bc; c++)
                    exp_q.push_back(d[k] ^ (INJ_ON && inj[k] && (r == REP / 2)));
        len = exp_q.size();
        cap = '0;
        start = 1'b1; data_in = d; err_inj = inj;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int i = 0; i < len; i++) begin
            cap = {cap[62:0], obs_bit};
            n_cmp++;
            if (obs_valid !== 1'b1 || obs_bit !== exp_q[i] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
                n_err++;
                $display("FAIL frame dut%0d sym%0d: valid=%b bit=%b busy=%b done=%b, required 1 %b 1 0",
                         sel, i, obs_valid, obs_bit, obs_busy, obs_done, exp_q[i]);
            end
            data_in = DW'($urandom);
            err_inj = DW'($urandom);
            if (i == poke_at) start = 1'b1;
            else if (!hold) start = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (obs_done !== 1'b1 || obs_valid !== 1'b0 || obs_bit !== 1'b0 || obs_busy !== 1'b1) begin
            n_err++;
            $display("FAIL done_cycle dut%0d: done=%b valid=%b bit=%b busy=%b, required 1 0 0 1",
                     sel, obs_done, obs_valid, obs_bit, obs_busy);
        end
        if (poke_done) start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        n_cmp++;
        if (obs_done !== 1'b0 || obs_valid !== 1'b0 || obs_bit !== 1'b0 || obs_busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after dut%0d: done=%b valid=%b bit=%b busy=%b, required 0 0 0 0",
                     sel, obs_done, obs_valid, obs_bit, obs_busy);
        end
    endtask

    task automatic test_reset();
        logic [63:0] cap;
        int len;
        rst_n = 1'b0; start = 1'b0; data_in = '0; err_inj = '0; sel = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            n_cmp++;
            if ({obs_bit, obs_valid, obs_busy, obs_done} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_state dut%0d: bit/valid/busy/done=%b, required 0000",
                         s, {obs_bit, obs_valid, obs_busy, obs_done});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            start = 1'b1; data_in = 5'b11011;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            n_cmp++;
            if ({obs_bit, obs_valid, obs_busy, obs_done} !== 4'b0000) begin
                n_err++;
                $display("FAIL midframe_reset dut%0d: bit/valid/busy/done=%b, required 0000",
                         s, {obs_bit, obs_valid, obs_busy, obs_done});
            end
            rst_n = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({obs_bit, obs_valid, obs_busy, obs_done} !== 4'b0000) begin
                n_err++;
                $display("FAIL after_reset_idle dut%0d: bit/valid/busy/done=%b, required 0000",
                         s, {obs_bit, obs_valid, obs_busy, obs_done});
            end
            check_frame(DW'($urandom), '0, 1'b0, -1, 1'b0, cap, len);
        end
        sel = 0;
    endtask

    task automatic test_basic();
        logic [63:0] cap;
        int len;
        sel = 0;
        check_frame(5'b10110, 5'b00000, 1'b0, -1, 1'b0, cap, len);
        n_cmp++;
        if (len != 15 || cap[14:0] !== 15'b111000111111000) begin
            n_err++;
            $display("FAIL basic_stream: got len=%0d %b, required 15 111000111111000", len, cap[14:0]);
        end
    endtask

    task automatic test_bit_cycles();
        logic [63:0] cap;
        int len;
        sel = 1;
        check_frame(5'b00001, 5'b00000, 1'b0, -1, 1'b0, cap, len);
        n_cmp++;
        if (len != 30 || cap[29:0] !== {24'd0, 6'b111111}) begin
            n_err++;
            $display("FAIL bit_cycles_stream: got len=%0d %b, required 30 24x0 then 6x1", len, cap[29:0]);
        end
        sel = 0;
    endtask

    task automatic test_ignore_start();
        logic [63:0] cap;
        int len;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            check_frame(5'b01101, 5'b00000, 1'b0, 5, 1'b1, cap, len);
            check_frame(5'b10010, 5'b00000, 1'b0, len - 1, 1'b1, cap, len);
        end
        sel = 0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] cap;
        int len;
        sel = 0;
        check_frame(5'b11111, 5'b00000, 1'b1, -1, 1'b0, cap, len);
        n_cmp++;
        if (cap[14:0] !== 15'h7fff) begin
            n_err++;
            $display("FAIL b2b_first: got %b, required all ones", cap[14:0]);
        end
        check_frame(5'b00000, 5'b00000, 1'b1, -1, 1'b0, cap, len);
        n_cmp++;
        if (cap[14:0] !== 15'h0000) begin
            n_err++;
            $display("FAIL b2b_second: got %b, required all zeros", cap[14:0]);
        end
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_stop: busy=%b valid=%b, required 0 0", obs_busy, obs_valid);
        end
    endtask

    task automatic test_err_inject();
        logic [63:0] cap;
        logic [14:0] want;
        logic [DW-1:0] dec;
        int len, bc;
`ifdef ERR_INJECT_EN
        want = 15'b101010101101010;
`else
        want = 15'b111000111111000;
`endif
        sel = 0;
        check_frame(5'b10110, 5'b11111, 1'b0, -1, 1'b0, cap, len);
        n_cmp++;
        if (cap[14:0] !== want) begin
            n_err++;
            $display("FAIL inject_stream: got %b, required %b", cap[14:0], want);
        end
        for (int s = 0; s < 2; s++) begin
            sel = s;
            bc = cur_bc();
            check_frame(5'b10110, 5'b11111, 1'b0, -1, 1'b0, cap, len);
            for (int j = 0; j < DW; j++) begin
                int ones = 0;
                for (int t = 0; t < REP * bc; t++)
                    ones += int'(cap[len - 1 - (j * REP * bc + t)]);
                dec[DW-1-j] = (2 * ones > REP * bc);
            end
            n_cmp++;
            if (dec !== 5'b10110) begin
                n_err++;
                $display("FAIL inject_majority dut%0d: decoded %b, required 10110", s, dec);
            end
        end
        sel = 0;
    endtask

    task automatic test_random();
        logic [63:0] cap;
        int len;
        for (int n = 0; n < 12; n++) begin
            sel = int'($urandom_range(1, 0));
            check_frame(DW'($urandom), DW'($urandom), 1'b0,
                        int'($urandom_range(40, 0)), 1'($urandom), cap, len);
        end
        sel = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_bit_cycles();
        test_ignore_start();
        test_back_to_back();
        test_err_inject();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
